load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory.
- Converts RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into the word-indexed, word-wide accesses that data_memory supports.
- Performs byte-lane extraction and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Reports misaligned or illegal accesses without touching memory.

Parameters:
- WORD_INDEX_WIDTH, 10, number of word-index bits driven on mem_address; upper bits are tied to zero.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents an access
- req_ready  output  1  unit can accept an access
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 of the load/store
- req_address  input  32  byte address
- req_store_data  input  32  store source register value
- resp_valid  output  1  one-cycle completion pulse
- resp_error  output  1  access was misaligned or illegal; qualified by resp_valid
- load_data  output  32  extended load result
- mem_read_enable  output  1  to data_memory
- mem_write_enable  output  1  to data_memory
- mem_address  output  32  word index (byte address >> 2), zero-extended above WORD_INDEX_WIDTH
- mem_write_data  output  32  to data_memory
- mem_read_data  input  32  from data_memory; combinational read, valid in the same cycle as mem_read_enable

Behaviour:
- Interface: single clock; reset_n is asynchronous and active-low; all state updates occur on the rising edge of clock.
- Reset (asynchronous, any time, including mid-access):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0, resp_error=0, load_data=0.
  - mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0.
  - An interrupted store never issues its write.
- FSM states: IDLE, LOAD_RD, STORE_RD, STORE_WR, RESP.
- Handshake:
  - req_ready=1 only in IDLE. A request is accepted on an edge where req_valid=1 and req_ready=1.
  - Address, funct3, write flag and store data are latched at acceptance; request inputs are ignored outside IDLE.
- Legality check at acceptance:
  - Loads: funct3 must be one of 000, 001, 010, 100, 101.
  - Stores: funct3 must be one of 000, 001, 010.
  - Halfword accesses require address[0]=0. Word accesses require address[1:0]=00.
  - On an illegal or misaligned access: go IDLE->RESP with resp_error=1; no mem enable is ever asserted.
- State transitions:
  - IDLE: load -> LOAD_RD; SW -> STORE_WR; SB/SH -> STORE_RD.
  - LOAD_RD: mem_read_enable=1. Capture mem_read_data and register the extracted result into load_data. -> RESP.
  - STORE_RD: mem_read_enable=1. Capture the old word. -> STORE_WR.
  - STORE_WR: mem_write_enable=1 for exactly one cycle. mem_write_data is the merged word: SB replaces byte lane address[1:0] with store_data[7:0]; SH replaces lane pair address[1] with store_data[15:0]; SW uses store_data unchanged. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle. -> IDLE.
- Memory-side outputs:
  - mem_address holds the latched word index throughout the access.
  - mem_address and mem_write_data are 0 when no enable is asserted.
  - mem_read_enable and mem_write_enable are never high together.
- Byte order: little-endian; byte lane n = bits [8n+7:8n].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- load_data holding rules:
  - load_data holds its value until the next load response.
  - Stores and errors drive load_data=0 in their RESP cycle and leave it 0 afterward.
- Latency, counted from the acceptance cycle (cycle 0):
  - Load: resp_valid in cycle 2.
  - SW: write in cycle 1, resp_valid in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- Back-to-back: a new request may be presented in the RESP cycle, but it is accepted only on the edge after RESP (req_ready is 0 in RESP). Maximum throughput is one access per 3 cycles for loads and SW, and one per 4 cycles for SB/SH.
- Address wrap: address bits above WORD_INDEX_WIDTH+1 are discarded, so the word index wraps modulo 2^WORD_INDEX_WIDTH.

Test Plan:
- Reset, then SW at address 0x0000_0010 with data 0xDEADBEEF -> cycle 1: mem_write_enable=1, mem_address=4, mem_write_data=0xDEADBEEF; cycle 2: resp_valid=1, resp_error=0.
- Word 4 = 0xDEADBEEF; LB at address 0x11 -> load_data=0xFFFFFFBE; LBU at 0x11 -> 0x000000BE; LH at 0x12 -> 0xFFFFDEAD; LHU at 0x12 -> 0x0000DEAD; LW at 0x10 -> 0xDEADBEEF; each with resp_valid in cycle 2.
- SB at address 0x12 with data 0x00000055 over word 4 = 0xDEADBEEF -> read in cycle 1, write 0xDE55BEEF in cycle 2, resp_valid in cycle 3; a following SH at 0x10 with data 0x1234 -> memory word 0xDE551234.
- LW at 0x13, SH at 0x11, and a load with funct3=011 -> each gives resp_valid=1 and resp_error=1 in cycle 1, with mem_read_enable and mem_write_enable 0 throughout.
- Assert reset_n=0 during the STORE_RD cycle of an SB -> outputs clear immediately; no write ever occurs; memory word unchanged; req_ready=1 after release.
- req_valid held high continuously with alternating LW/SW -> exactly one acceptance per 3 cycles, req_ready=0 outside IDLE, and a single resp_valid pulse per access.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data_memory-side signals of the load/store unit.
// slave is the unit's view; master is the core+memory view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] load_data;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_store_data, mem_read_data,
    input  req_ready, resp_valid, resp_error, load_data,
           mem_read_enable, mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_store_data, mem_read_data,
    output req_ready, resp_valid, resp_error, load_data,
           mem_read_enable, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-wide
// data_memory, with lane extraction, sign/zero extension and read-modify-write stores.
module load_store_unit #(
  parameter int unsigned WORD_INDEX_WIDTH = 10
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RD,
    STORE_RD,
    STORE_WR,
    RESP
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_byte_off;
  logic [31:0] r_store_data;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_load_data;
  logic        r_mem_read_enable;
  logic        r_mem_write_enable;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;

  logic        w_legal;
  logic [31:0] w_word_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;
  logic        w_unused;

  // Address bits above the word index are dropped, so the index wraps.
  assign w_word_addr = 32'(bus.req_address[WORD_INDEX_WIDTH+1:2]);
  assign w_unused    = &{1'b0, bus.req_address[31:WORD_INDEX_WIDTH+2]};

  always_comb begin
    w_legal = 1'b0;
    case (bus.req_funct3)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = ~bus.req_address[0];
      3'b010:  w_legal = (bus.req_address[1:0] == 2'b00);
      3'b100:  w_legal = ~bus.req_write;
      3'b101:  w_legal = ~bus.req_write & ~bus.req_address[0];
      default: w_legal = 1'b0;
    endcase
  end

  assign w_byte = bus.mem_read_data[{r_byte_off, 3'b000} +: 8];
  assign w_half = r_byte_off[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

  // funct3[2] selects the unsigned variants; only sub-word loads reach the sign fill.
  always_comb begin
    w_load_ext = bus.mem_read_data;
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   w_load_ext = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_load_ext = bus.mem_read_data;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_read_data;
    case (r_funct3[1:0])
      2'b00: w_merged[{r_byte_off, 3'b000} +: 8] = r_store_data[7:0];
      2'b01: begin
        if (r_byte_off[1]) w_merged[31:16] = r_store_data[15:0];
        else               w_merged[15:0]  = r_store_data[15:0];
      end
      default: w_merged = r_store_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= IDLE;
      r_funct3           <= '0;
      r_byte_off         <= '0;
      r_store_data       <= '0;
      r_req_ready        <= 1'b1;
      r_resp_valid       <= 1'b0;
      r_resp_error       <= 1'b0;
      r_load_data        <= '0;
      r_mem_read_enable  <= 1'b0;
      r_mem_write_enable <= 1'b0;
      r_mem_address      <= '0;
      r_mem_write_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_funct3     <= bus.req_funct3;
            r_byte_off   <= bus.req_address[1:0];
            r_store_data <= bus.req_store_data;
            r_req_ready  <= 1'b0;
            if (!w_legal) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_load_data  <= '0;
            end else if (!bus.req_write) begin
              r_state           <= LOAD_RD;
              r_mem_read_enable <= 1'b1;
              r_mem_address     <= w_word_addr;
            end else if (bus.req_funct3 == 3'b010) begin
              r_state            <= STORE_WR;
              r_mem_write_enable <= 1'b1;
              r_mem_address      <= w_word_addr;
              r_mem_write_data   <= bus.req_store_data;
            end else begin
              r_state           <= STORE_RD;
              r_mem_read_enable <= 1'b1;
              r_mem_address     <= w_word_addr;
            end
          end
        end
        LOAD_RD: begin
          r_state           <= RESP;
          r_mem_read_enable <= 1'b0;
          r_mem_address     <= '0;
          r_load_data       <= w_load_ext;
          r_resp_valid      <= 1'b1;
        end
        STORE_RD: begin
          r_state            <= STORE_WR;
          r_mem_read_enable  <= 1'b0;
          r_mem_write_enable <= 1'b1;
          r_mem_write_data   <= w_merged;
        end
        STORE_WR: begin
          r_state            <= RESP;
          r_mem_write_enable <= 1'b0;
          r_mem_address      <= '0;
          r_mem_write_data   <= '0;
          r_load_data        <= '0;
          r_resp_valid       <= 1'b1;
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready        = r_req_ready;
  assign bus.resp_valid       = r_resp_valid;
  assign bus.resp_error       = r_resp_error;
  assign bus.load_data        = r_load_data;
  assign bus.mem_read_enable  = r_mem_read_enable;
  assign bus.mem_write_enable = r_mem_write_enable;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_write_data   = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-cycle comparison against a latency-table model with a
// reference memory, plus directed transactions with literal expected results.
module tb_load_store_unit;

  localparam int K_LOAD = 0;
  localparam int K_SW   = 1;
  localparam int K_SUB  = 2;
  localparam int K_ERR  = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   resp_count = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  load_store_unit_if bus ();

  load_store_unit #(.WORD_INDEX_WIDTH(10)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign bus.mem_read_data = mem[bus.mem_address[9:0]];
  always @(posedge clock)
    if (bus.mem_write_enable) mem[bus.mem_address[9:0]] <= bus.mem_write_data;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC300_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] size_mask(int size);
    return (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] word, int f3, int off);
    int size;
    logic [31:0] mask, v;
    size = 1 << (f3 % 4);
    mask = size_mask(size);
    v    = (word >> (8 * off)) & mask;
    if (f3 < 4 && size < 4 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] data, int f3, int off);
    int size;
    logic [31:0] mask;
    size = 1 << (f3 % 4);
    mask = size_mask(size);
    return (old & ~(mask << (8 * off))) | ((data & mask) << (8 * off));
  endfunction

  // Reference model: one access in flight, outputs derived from its age in cycles.
  bit          m_busy = 0;
  int          m_age, m_lat, m_kind, m_f3, m_off, m_idx;
  logic [31:0] m_data, m_pend;
  logic [31:0] m_load = '0;

  initial begin
    bit          e_rv, e_re, e_we, legal;
    logic [31:0] e_wd, a;
    int          size;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        m_busy = 0;
        m_load = '0;
      end
      e_rv = m_busy && (m_age == m_lat);
      e_re = m_busy && m_age == 1 && (m_kind == K_LOAD || m_kind == K_SUB);
      e_we = m_busy && ((m_kind == K_SW && m_age == 1) || (m_kind == K_SUB && m_age == 2));
      e_wd = '0;
      if (e_re && m_kind == K_LOAD) m_pend = load_ext(ref_mem[m_idx], m_f3, m_off);
      if (e_we) e_wd = (m_kind == K_SW) ? m_data : merge(ref_mem[m_idx], m_data, m_f3, m_off);
      if (e_rv) m_load = (m_kind == K_LOAD) ? m_pend : '0;
      if (bus.resp_valid === 1'b1) resp_count++;

      chk("req_ready",  32'(bus.req_ready),        32'(!m_busy));
      chk("resp_valid", 32'(bus.resp_valid),       32'(e_rv));
      chk("resp_error", 32'(bus.resp_error),       32'(e_rv && m_kind == K_ERR));
      chk("load_data",  bus.load_data,             m_load);
      chk("mem_re",     32'(bus.mem_read_enable),  32'(e_re));
      chk("mem_we",     32'(bus.mem_write_enable), 32'(e_we));
      chk("mem_addr",   bus.mem_address,           (e_re || e_we) ? 32'(m_idx) : 32'h0);
      chk("mem_wdata",  bus.mem_write_data,        e_wd);

      if (e_we) ref_mem[m_idx] = e_wd;
      if (reset_n) begin
        if (m_busy) begin
          if (m_age == m_lat) m_busy = 0;
          else m_age++;
        end else if (bus.req_valid) begin
          a      = bus.req_address;
          m_f3   = int'(bus.req_funct3);
          size   = 1 << (m_f3 % 4);
          legal  = bus.req_write ? (m_f3 <= 2)
                                 : (m_f3 == 0 || m_f3 == 1 || m_f3 == 2 || m_f3 == 4 || m_f3 == 5);
          legal  = legal && (a % size == 0);
          m_kind = !legal ? K_ERR : !bus.req_write ? K_LOAD : (m_f3 == 2) ? K_SW : K_SUB;
          m_lat  = (m_kind == K_ERR) ? 1 : (m_kind == K_SUB) ? 3 : 2;
          m_idx  = int'((a / 4) % 1024);
          m_off  = int'(a % 4);
          m_data = bus.req_store_data;
          m_busy = 1;
          m_age  = 1;
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, output int lat, output logic [31:0] ld,
                        output logic err);
    bit acc;
    logic rdy;
    acc = 0;
    lat = 0;
    ld  = 'x;
    err = 'x;
    @(posedge clock);
    #1;
    bus.req_valid      = 1'b1;
    bus.req_write      = w;
    bus.req_funct3     = f3;
    bus.req_address    = addr;
    bus.req_store_data = data;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clock);
      rdy = bus.req_ready;
      @(posedge clock);
      if (rdy) acc = 1;
    end
    #1 bus.req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        lat = c;
        ld  = bus.load_data;
        err = bus.resp_error;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] ld;
    logic err, rdy, w;
    int n_acc, last, rc0;

    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_funct3     = '0;
    bus.req_address    = '0;
    bus.req_store_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_load_data", bus.load_data, 32'h0);
    chk("rst_mem_addr", bus.mem_address, 32'h0);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, ld, err);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(err), 32'h0);
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);

    do_req(1'b0, 3'b000, 32'h11, '0, lat, ld, err);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_data", ld, 32'hFFFF_FFBE);
    do_req(1'b0, 3'b100, 32'h11, '0, lat, ld, err);
    chk("lbu_data", ld, 32'h0000_00BE);
    do_req(1'b0, 3'b001, 32'h12, '0, lat, ld, err);
    chk("lh_data", ld, 32'hFFFF_DEAD);
    do_req(1'b0, 3'b101, 32'h12, '0, lat, ld, err);
    chk("lhu_data", ld, 32'h0000_DEAD);
    do_req(1'b0, 3'b010, 32'h10, '0, lat, ld, err);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_data", ld, 32'hDEAD_BEEF);

    do_req(1'b1, 3'b000, 32'h12, 32'h0000_0055, lat, ld, err);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_mem", mem[4], 32'hDE55_BEEF);
    chk("sb_load_data", ld, 32'h0);
    do_req(1'b1, 3'b001, 32'h10, 32'h0000_1234, lat, ld, err);
    chk("sh_mem", mem[4], 32'hDE55_1234);

    do_req(1'b0, 3'b010, 32'h13, '0, lat, ld, err);
    chk("err_lw_lat", 32'(lat), 32'd1);
    chk("err_lw_err", 32'(err), 32'h1);
    do_req(1'b1, 3'b001, 32'h11, 32'h9999, lat, ld, err);
    chk("err_sh_lat", 32'(lat), 32'd1);
    chk("err_sh_err", 32'(err), 32'h1);
    do_req(1'b0, 3'b011, 32'h10, '0, lat, ld, err);
    chk("err_f3_err", 32'(err), 32'h1);
    do_req(1'b1, 3'b100, 32'h10, 32'h77, lat, ld, err);
    chk("err_st_f3_err", 32'(err), 32'h1);
    chk("err_mem_kept", mem[4], 32'hDE55_1234);

    // Reset during the read half of an SB: write must never happen.
    @(posedge clock);
    #1;
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b1;
    bus.req_funct3     = 3'b000;
    bus.req_address    = 32'h15;
    bus.req_store_data = 32'h77;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    chk("rst_mid_re", 32'(bus.mem_read_enable), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_re_clr", 32'(bus.mem_read_enable), 32'h0);
    chk("rst_mid_addr", bus.mem_address, 32'h0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mid_mem", mem[5], init_word(5));
    chk("rst_mid_ready_after", 32'(bus.req_ready), 32'h1);

    // Continuous req_valid, alternating LW/SW to word 6.
    rc0   = resp_count;
    n_acc = 0;
    last  = 0;
    w     = 1'b0;
    @(posedge clock);
    #1;
    bus.req_valid      = 1'b1;
    bus.req_write      = w;
    bus.req_funct3     = 3'b010;
    bus.req_address    = 32'h18;
    bus.req_store_data = 32'hA500_0000;
    for (int k = 0; k < 40 && n_acc < 6; k++) begin
      @(negedge clock);
      rdy = bus.req_ready;
      @(posedge clock);
      if (rdy) begin
        if (n_acc > 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        n_acc++;
        #1;
        w = ~w;
        bus.req_write      = w;
        bus.req_store_data = 32'hA500_0000 + 32'(n_acc);
      end
    end
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("b2b_accepts", 32'(n_acc), 32'd6);
    chk("b2b_resps", 32'(resp_count - rc0), 32'd6);
    chk("b2b_mem", mem[6], 32'hA500_0005);

    do_req(1'b1, 3'b010, 32'h0000_1004, 32'h1357_2468, lat, ld, err);
    chk("wrap_mem", mem[1], 32'h1357_2468);
    do_req(1'b0, 3'b010, 32'h0000_0004, '0, lat, ld, err);
    chk("wrap_lw", ld, 32'h1357_2468);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
